// File: rtl/mux_counter_ctrl.sv
// rtl/mux_counter_ctrl.sv - capture, BCD conversion and multiplexed display sequencer for a 10-bit event counter
//
// Ports:
//   CLK        sole clock, rising edge
//   RST        synchronous reset, active-low
//   COUNT      counter value to capture, binary 0..1023
//   CAPTURE    capture request, sampled every edge
//   BUSY       high while a captured value is being converted
//   DONE       one-cycle pulse when new display digits are valid
//   CNT_CLR    one-cycle active-high clear to the counter
//   DIGIT_EN   one-hot digit enable (bit 0 = ones), zero when the digit is blanked
//   DIGIT_BCD  BCD value of the selected digit
module mux_counter_ctrl #(
    parameter int SCAN_DIV         = 1000,
    parameter bit CLEAR_ON_CAPTURE = 1'b1,
    parameter bit BLANK_LZ         = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] COUNT,
    input  logic       CAPTURE,
    output logic       BUSY,
    output logic       DONE,
    output logic       CNT_CLR,
    output logic [3:0] DIGIT_EN,
    output logic [3:0] DIGIT_BCD
);

    typedef enum logic {IDLE, CONV} state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    state_t      state;
    logic [9:0]  shadow;
    logic [15:0] scratch;
    logic [3:0]  step;
    logic [15:0] disp;
    logic [15:0] presc;
    logic [1:0]  index;

    logic [15:0] adj;
    logic [15:0] scratch_next;
    logic        last_step;
    logic [15:0] disp_next;
    logic        presc_wrap;
    logic [1:0]  index_next;
    logic        blank;
    logic [3:0]  en_next;
    logic [3:0]  bcd_next;

    // One shift-add-3 step: correct every nibble >= 5 before the shift so
    // it carries into the next BCD digit instead of exceeding 9.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {adj[14:0], shadow[9]};
        last_step    = (step == 4'd9);
    end

    // Digit outputs are registered from next-state values so the bus shows
    // the new index and the new digits on the same edge they change.
    always_comb begin
        disp_next  = (state == CONV && last_step) ? scratch_next : disp;
        presc_wrap = (presc == SCAN_LAST);
        index_next = presc_wrap ? index + 2'd1 : index;
        bcd_next   = disp_next[{index_next, 2'b00} +: 4];
        blank      = 1'b0;
        case (index_next)
            2'd1:    blank = (disp_next[15:4]  == 12'd0);
            2'd2:    blank = (disp_next[15:8]  == 8'd0);
            2'd3:    blank = (disp_next[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        en_next = (BLANK_LZ && blank) ? 4'b0000 : (4'b0001 << index_next);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            shadow    <= '0;
            scratch   <= '0;
            step      <= '0;
            disp      <= '0;
            presc     <= '0;
            index     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            CNT_CLR   <= 1'b0;
            DIGIT_EN  <= 4'b0001;
            DIGIT_BCD <= 4'd0;
        end else begin
            presc     <= presc_wrap ? 16'd0 : presc + 16'd1;
            index     <= index_next;
            disp      <= disp_next;
            DIGIT_EN  <= en_next;
            DIGIT_BCD <= bcd_next;
            DONE      <= 1'b0;
            CNT_CLR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (CAPTURE) begin
                        state   <= CONV;
                        shadow  <= COUNT;
                        scratch <= '0;
                        step    <= '0;
                        BUSY    <= 1'b1;
                        CNT_CLR <= CLEAR_ON_CAPTURE;
                    end
                end
                CONV: begin
                    scratch <= scratch_next;
                    shadow  <= {shadow[8:0], 1'b0};
                    step    <= step + 4'd1;
                    if (last_step) begin
                        DONE <= 1'b1;
                        // The completing edge already counts as idle, so a
                        // request here starts the next conversion directly.
                        if (CAPTURE) begin
                            shadow  <= COUNT;
                            scratch <= '0;
                            step    <= '0;
                            CNT_CLR <= CLEAR_ON_CAPTURE;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_counter_ctrl.sv
// tb/tb_mux_counter_ctrl.sv - directed self-checking bench for mux_counter_ctrl
module tb_mux_counter_ctrl;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] count1 = '0, count2 = '0;
    logic       cap1 = 1'b0, cap2 = 1'b0;
    logic       busy1, done1, clr1, busy2, done2, clr2;
    logic [3:0] en1, bcd1, en2, bcd2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    mux_counter_ctrl #(.SCAN_DIV(SD), .CLEAR_ON_CAPTURE(1'b1), .BLANK_LZ(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .COUNT(count1), .CAPTURE(cap1),
        .BUSY(busy1), .DONE(done1), .CNT_CLR(clr1), .DIGIT_EN(en1), .DIGIT_BCD(bcd1)
    );

    mux_counter_ctrl #(.SCAN_DIV(SD), .CLEAR_ON_CAPTURE(1'b0), .BLANK_LZ(1'b1)) dut2 (
        .CLK(clk), .RST(rst), .COUNT(count2), .CAPTURE(cap2),
        .BUSY(busy2), .DONE(done2), .CNT_CLR(clr2), .DIGIT_EN(en2), .DIGIT_BCD(bcd2)
    );

    // Advance one edge; cyc tracks edges since the last reset edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) cyc = 0;
        else cyc++;
        #1;
    endtask

    // Expected enable for index idx of display value d.
    function automatic logic [3:0] exp_en(input logic [15:0] d, input int idx);
        logic shown;
        shown = 1'b1;
        if (idx == 1) shown = (d[15:4] != 0);
        if (idx == 2) shown = (d[15:8] != 0);
        if (idx == 3) shown = (d[15:12] != 0);
        return shown ? (4'b0001 << idx) : 4'b0000;
    endfunction

    // Scan a full rotation and compare against the expected digits.
    task automatic check_display(input bit which, input logic [15:0] d, input string tag);
        int idx;
        logic [3:0] e_en, e_bcd, a_en, a_bcd;
        for (int j = 0; j < 4 * SD; j++) begin
            tick();
            idx   = (cyc / SD) % 4;
            e_en  = exp_en(d, idx);
            e_bcd = d[4*idx +: 4];
            a_en  = which ? en2 : en1;
            a_bcd = which ? bcd2 : bcd1;
            n_checks += 2;
            if (a_en !== e_en) begin
                n_fail++;
                $display("FAIL %s digit_en cyc=%0d actual=%b required=%b", tag, cyc, a_en, e_en);
            end
            if (a_bcd !== e_bcd) begin
                n_fail++;
                $display("FAIL %s digit_bcd cyc=%0d actual=%0d required=%0d", tag, cyc, a_bcd, e_bcd);
            end
        end
    endtask

    // One capture at edge k, checking BUSY/CNT_CLR/DONE through edge k+10.
    task automatic do_capture(input bit which, input logic [9:0] v, input string tag);
        logic a_busy, a_done, a_clr, e_clr;
        if (which) begin count2 = v; cap2 = 1'b1; end
        else begin count1 = v; cap1 = 1'b1; end
        for (int j = 0; j <= 10; j++) begin
            tick();
            cap1 = 1'b0;
            cap2 = 1'b0;
            a_busy = which ? busy2 : busy1;
            a_done = which ? done2 : done1;
            a_clr  = which ? clr2 : clr1;
            e_clr  = (j == 0) && !which;
            n_checks += 3;
            if (a_clr !== e_clr) begin
                n_fail++;
                $display("FAIL %s cnt_clr k+%0d actual=%b required=%b", tag, j, a_clr, e_clr);
            end
            if (a_done !== (j == 10)) begin
                n_fail++;
                $display("FAIL %s done k+%0d actual=%b required=%b", tag, j, a_done, (j == 10));
            end
            if (a_busy !== (j != 10)) begin
                n_fail++;
                $display("FAIL %s busy k+%0d actual=%b required=%b", tag, j, a_busy, (j != 10));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks += 5;
        if (busy1 !== 1'b0)    begin n_fail++; $display("FAIL reset busy actual=%b required=0", busy1); end
        if (done1 !== 1'b0)    begin n_fail++; $display("FAIL reset done actual=%b required=0", done1); end
        if (clr1 !== 1'b0)     begin n_fail++; $display("FAIL reset cnt_clr actual=%b required=0", clr1); end
        if (en1 !== 4'b0001)   begin n_fail++; $display("FAIL reset digit_en actual=%b required=0001", en1); end
        if (bcd1 !== 4'd0)     begin n_fail++; $display("FAIL reset digit_bcd actual=%0d required=0", bcd1); end
        rst = 1'b1;
        check_display(1'b0, 16'h0000, "reset_scan");
    endtask

    task automatic test_capture_1023();
        do_capture(1'b0, 10'd1023, "cap1023");
        check_display(1'b0, 16'h1023, "scan1023");
    endtask

    task automatic test_blanking();
        do_capture(1'b0, 10'd0, "cap0");
        check_display(1'b0, 16'h0000, "scan0");
        do_capture(1'b0, 10'd47, "cap47");
        check_display(1'b0, 16'h0047, "scan47");
    endtask

    task automatic test_back_to_back();
        int idx;
        logic [15:0] d;
        count1 = 10'd300;
        cap1 = 1'b1;
        tick();
        cap1 = 1'b0;
        count1 = 10'd5;
        for (int j = 1; j <= 9; j++) begin
            cap1 = (j == 3 || j == 9);
            tick();
            n_checks++;
            if (done1 !== 1'b0) begin n_fail++; $display("FAIL repulse done k+%0d actual=%b required=0", j, done1); end
        end
        cap1 = 1'b1;
        count1 = 10'd77;
        tick();
        cap1 = 1'b0;
        d = 16'h0300;
        idx = (cyc / SD) % 4;
        n_checks += 4;
        if (done1 !== 1'b1) begin n_fail++; $display("FAIL repulse done k+10 actual=%b required=1", done1); end
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL held_capture busy k+10 actual=%b required=1", busy1); end
        if (bcd1 !== d[4*idx +: 4]) begin n_fail++; $display("FAIL repulse result bcd actual=%0d required=%0d", bcd1, d[4*idx +: 4]); end
        if (en1 !== exp_en(d, idx)) begin n_fail++; $display("FAIL repulse result en actual=%b required=%b", en1, exp_en(d, idx)); end
        for (int j = 11; j <= 20; j++) begin
            tick();
            n_checks++;
            if (done1 !== (j == 20)) begin n_fail++; $display("FAIL held_capture done k+%0d actual=%b required=%b", j, done1, (j == 20)); end
        end
        check_display(1'b0, 16'h0077, "scan77");
    endtask

    task automatic test_reset_mid();
        do_capture(1'b0, 10'd512, "cap512");
        check_display(1'b0, 16'h0512, "scan512");
        count1 = 10'd100;
        cap1 = 1'b1;
        tick();
        cap1 = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks += 5;
        if (busy1 !== 1'b0)  begin n_fail++; $display("FAIL midreset busy actual=%b required=0", busy1); end
        if (done1 !== 1'b0)  begin n_fail++; $display("FAIL midreset done actual=%b required=0", done1); end
        if (clr1 !== 1'b0)   begin n_fail++; $display("FAIL midreset cnt_clr actual=%b required=0", clr1); end
        if (en1 !== 4'b0001) begin n_fail++; $display("FAIL midreset digit_en actual=%b required=0001", en1); end
        if (bcd1 !== 4'd0)   begin n_fail++; $display("FAIL midreset digit_bcd actual=%0d required=0", bcd1); end
        for (int j = 0; j < 12; j++) begin
            tick();
            n_checks += 2;
            if (done1 !== 1'b0) begin n_fail++; $display("FAIL midreset stray done cyc=%0d actual=%b", cyc, done1); end
            if (busy1 !== 1'b0) begin n_fail++; $display("FAIL midreset stray busy cyc=%0d actual=%b", cyc, busy1); end
        end
        check_display(1'b0, 16'h0000, "scan_after_reset");
        do_capture(1'b0, 10'd999, "cap999");
        check_display(1'b0, 16'h0999, "scan999");
    endtask

    task automatic test_no_clear();
        do_capture(1'b1, 10'd600, "noclr600");
        check_display(1'b1, 16'h0600, "scan600");
    endtask

    initial begin
        test_reset();
        test_capture_1023();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        test_no_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
